// File: rtl/lmul_pkg.sv
// Shared definitions for schedulers that front the LMUL_unit BF16 multiplier.
package lmul_pkg;

  localparam int BF16_W      = 16;
  localparam int RES_W       = 32;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// after the pointer, wrapping from N-1 back to 0.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_id,
  output logic         any
);

  // Scan offsets 0..N-1 from the pointer; the first hit wins.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!any && req[j] && (j == ((int'(ptr) + i) % N))) begin
          any      = 1'b1;
          grant[j] = 1'b1;
          grant_id = W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/lmul_scheduler.sv
// Shares one LMUL_unit among N_REQ requesters: round-robin accept, one-cycle
// start pulse, wait for the unit's ready (with a watchdog), then return the
// tagged result over a valid/ready response channel.
module lmul_scheduler
  import lmul_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*BF16_W-1:0] req_a,
  input  logic [N_REQ*BF16_W-1:0] req_b,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [RES_W-1:0]        rsp_data,
  output logic                    rsp_err,
  output logic                    mul_start,
  output logic [BF16_W-1:0]       mul_a,
  output logic [BF16_W-1:0]       mul_b,
  input  logic                    mul_ready,
  input  logic [RES_W-1:0]        mul_out,
  output logic                    busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  sched_state_e       state_q, state_d;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    cur_id;
  logic [ID_W-1:0]    grant_id;
  logic [N_REQ-1:0]   grant;
  logic               grant_any;
  logic [BF16_W-1:0]  op_a, op_b;
  logic [BF16_W-1:0]  sel_a, sel_b;
  logic [CNT_W-1:0]   wait_cnt;
  logic               blank;
  logic               accept, done_ok, done_to, rsp_hs;

  rr_arbiter #(
    .N (N_REQ),
    .W (ID_W)
  ) u_arb (
    .req      (req_valid),
    .ptr      (rr_ptr),
    .grant    (grant),
    .grant_id (grant_id),
    .any      (grant_any)
  );

  // Only IDLE offers a grant; everything else is busy.
  assign req_ready = (state_q == ST_IDLE) ? grant : '0;
  assign busy      = (state_q != ST_IDLE);
  assign mul_a     = op_a;
  assign mul_b     = op_b;
  assign rsp_id    = cur_id;

  // Select the granted requester's operands (grant is one-hot or zero).
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*BF16_W +: BF16_W];
        sel_b = req_b[i*BF16_W +: BF16_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode plus one-cycle event strobes for the datapath.
  // The first WAIT cycle is blanking: a ready left high by the previous
  // operation is ignored and that cycle is not counted by the watchdog.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done_ok = 1'b0;
    done_to = 1'b0;
    rsp_hs  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          accept  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (!blank) begin
          if (mul_ready) begin
            done_ok = 1'b1;
            state_d = ST_RESP;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            done_to = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_hs  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered operands, start pulse, watchdog, response and pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a      <= '0;
      op_b      <= '0;
      cur_id    <= '0;
      mul_start <= 1'b0;
      wait_cnt  <= '0;
      blank     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      rr_ptr    <= '0;
    end else begin
      mul_start <= accept;
      if (accept) begin
        op_a   <= sel_a;
        op_b   <= sel_b;
        cur_id <= grant_id;
      end
      if (state_q == ST_ISSUE) begin
        wait_cnt <= '0;
        blank    <= 1'b1;
      end else if (state_q == ST_WAIT) begin
        if (blank) blank    <= 1'b0;
        else       wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (done_ok) begin
        rsp_valid <= 1'b1;
        rsp_data  <= mul_out;
        rsp_err   <= 1'b0;
      end else if (done_to) begin
        rsp_valid <= 1'b1;
        rsp_data  <= '0;
        rsp_err   <= 1'b1;
      end else if (rsp_hs) begin
        rsp_valid <= 1'b0;
      end
      if (rsp_hs) begin
        rr_ptr <= (cur_id == ID_W'(N_REQ - 1)) ? '0 : cur_id + ID_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lmul_scheduler.sv
// Scoreboard bench for lmul_scheduler with a behavioural LMUL_unit model
// (LATENCY=5) that can be switched to never raise ready.
module tb_lmul_scheduler;
  import lmul_pkg::*;

  localparam int LAT = 5;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  localparam logic [15:0] TAB_A [4] = '{16'h3F80, 16'hBF80, 16'h4040, 16'h3FC0};
  localparam logic [15:0] TAB_B [4] = '{16'h4000, 16'h4000, 16'h4000, 16'h3FC0};
  localparam logic [31:0] TAB_P [4] = '{32'h4000_0000, 32'hC000_0000,
                                        32'h40C0_0000, 32'h4010_0000};

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_a, req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        mul_start;
  logic [15:0] mul_a, mul_b;
  logic        mul_ready = 1'b0;
  logic [31:0] mul_out = '0;
  logic        busy;

  lmul_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .mul_start (mul_start),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_ready (mul_ready),
    .mul_out   (mul_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t exp_q[$];
  int   acc_q[$];
  int   n_acc = 0;
  logic [1:0] last_acc_idx = '0;
  bit   chk_spacing = 0;
  bit   have_prev = 0;
  int   prev_acc = 0;
  bit   stub_dead = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Truncating BF16 multiply, normal operands only.
  function automatic logic [15:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] p;
    logic [9:0]  e;
    logic [6:0]  m;
    p = {8'h00, 1'b1, a[6:0]} * {8'h00, 1'b1, b[6:0]};
    e = {2'b00, a[14:7]} + {2'b00, b[14:7]} - 10'd127;
    if (p[15]) begin
      m = p[14:8];
      e = e + 10'd1;
    end else begin
      m = p[13:7];
    end
    return {a[15] ^ b[15], e[7:0], m};
  endfunction

  // LMUL_unit model: samples start, raises ready LAT+1 edges later, holds it.
  logic [15:0] st_a = '0, st_b = '0;
  int          st_cnt = 0;
  bit          st_run = 0;
  always @(posedge clk) begin
    if (mul_start) begin
      st_a      <= mul_a;
      st_b      <= mul_b;
      st_cnt    <= LAT;
      st_run    <= 1'b1;
      mul_ready <= 1'b0;
    end else if (st_run) begin
      if (st_cnt == 0) begin
        st_run <= 1'b0;
        if (!stub_dead) begin
          mul_ready <= 1'b1;
          mul_out   <= {bf16_mul(st_a, st_b), 16'h0000};
        end
      end else begin
        st_cnt <= st_cnt - 1;
      end
    end
  end

  always @(posedge clk) cyc++;

  // Monitor on the falling edge: accepts, response timing, stability, scoreboard.
  logic        rsp_valid_d = 1'b0;
  bit          hs_prev = 0;
  logic [1:0]  hold_id;
  logic [31:0] hold_data;
  logic        hold_err;
  always @(negedge clk) begin
    if (rst) begin
      rsp_valid_d = 1'b0;
      hs_prev     = 0;
    end else begin
      if (hs_prev && (|req_valid)) check_eq("resume_accept", {63'd0, |req_ready}, 64'd1);
      hs_prev = 0;
      if (|(req_valid & req_ready)) begin
        check_eq("acc_onehot", 64'($countones(req_ready)), 64'd1);
        for (int i = 0; i < 4; i++) if (req_ready[i]) last_acc_idx = 2'(i);
        acc_q.push_back(cyc);
        n_acc++;
        if (chk_spacing && have_prev) check_eq("acc_spacing", 64'(cyc - prev_acc), 64'(LAT + 5));
        prev_acc  = cyc;
        have_prev = 1;
      end
      if (rsp_valid && !rsp_valid_d) begin
        hold_id   = rsp_id;
        hold_data = rsp_data;
        hold_err  = rsp_err;
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          check_eq("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          int a;
          a = acc_q.pop_front();
          check_eq("rsp_latency", 64'(cyc - (a + 1)), 64'(exp_q[0].lat));
        end
      end else if (rsp_valid) begin
        check_eq("hold_id", {62'd0, rsp_id}, {62'd0, hold_id});
        check_eq("hold_data", {32'd0, rsp_data}, {32'd0, hold_data});
        check_eq("hold_err", {63'd0, rsp_err}, {63'd0, hold_err});
        check_eq("rdy_in_resp", {60'd0, req_ready}, 64'd0);
      end
      if (rsp_valid && rsp_ready && exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("rsp_id", {62'd0, rsp_id}, {62'd0, e.id});
        check_eq("rsp_data", {32'd0, rsp_data}, {32'd0, e.data});
        check_eq("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
        hs_prev = 1;
      end
      rsp_valid_d = rsp_valid;
    end
  end

  task automatic push_exp(input logic [1:0] id, input logic [31:0] data, input logic err, input int lat);
    exp_t e;
    e.id = id; e.data = data; e.err = err; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
    req_valid[i]      = 1'b1;
  endtask

  task automatic wait_accepts(input int n, input bit keep);
    int base, seen, budget;
    base = n_acc; seen = 0; budget = 0;
    while (seen < n && budget < 400) begin
      @(posedge clk); #1;
      budget++;
      while (seen < n_acc - base) begin
        seen++;
        if (!keep) req_valid[last_acc_idx] = 1'b0;
      end
    end
    if (seen < n) check_eq("accept_wait", 64'(seen), 64'(n));
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    while (exp_q.size() > 0 && budget < 400) begin
      @(posedge clk); #1;
      budget++;
    end
    if (exp_q.size() > 0) check_eq("drain_wait", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_req_ready"}, {60'd0, req_ready}, 64'd0);
    check_eq({pfx, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
    check_eq({pfx, "_rsp_id"},    {62'd0, rsp_id},    64'd0);
    check_eq({pfx, "_rsp_data"},  {32'd0, rsp_data},  64'd0);
    check_eq({pfx, "_rsp_err"},   {63'd0, rsp_err},   64'd0);
    check_eq({pfx, "_mul_start"}, {63'd0, mul_start}, 64'd0);
    check_eq({pfx, "_mul_a"},     {48'd0, mul_a},     64'd0);
    check_eq({pfx, "_mul_b"},     {48'd0, mul_b},     64'd0);
    check_eq({pfx, "_busy"},      {63'd0, busy},      64'd0);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single request on requester 0: 1.0 * 2.0.
    push_exp(2'd0, 32'h4000_0000, 1'b0, LAT + 3);
    set_req(0, 16'h3F80, 16'h4000);
    wait_accepts(1, 0);
    wait_drain();

    // Sign handling on requester 3: -1.0 * 2.0 (pointer then wraps to 0).
    push_exp(2'd3, 32'hC000_0000, 1'b0, LAT + 3);
    set_req(3, 16'hBF80, 16'h4000);
    wait_accepts(1, 0);
    wait_drain();

    // Round-robin with all four requesting and the consumer always ready.
    for (int k = 0; k < 5; k++) push_exp(2'(k % 4), TAB_P[k % 4], 1'b0, LAT + 3);
    for (int i = 0; i < 4; i++) begin
      req_a[16*i +: 16] = TAB_A[i];
      req_b[16*i +: 16] = TAB_B[i];
    end
    have_prev   = 0;
    chk_spacing = 1;
    req_valid   = 4'hF;
    wait_accepts(5, 1);
    req_valid   = '0;
    chk_spacing = 0;
    wait_drain();

    // Backpressure: consumer stalls 5 cycles while requester 2 waits.
    rsp_ready = 1'b0;
    push_exp(2'd1, TAB_P[1], 1'b0, LAT + 3);
    push_exp(2'd2, TAB_P[2], 1'b0, LAT + 3);
    set_req(1, TAB_A[1], TAB_B[1]);
    wait_accepts(1, 0);
    set_req(2, TAB_A[2], TAB_B[2]);
    begin
      int budget;
      budget = 0;
      while (!rsp_valid && budget < 100) begin
        @(posedge clk); #1;
        budget++;
      end
      if (!rsp_valid) check_eq("bp_rsp_wait", 64'd0, 64'd1);
    end
    repeat (5) @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_accepts(1, 0);
    wait_drain();

    // Watchdog: the unit never raises ready for requester 3.
    stub_dead = 1;
    push_exp(2'd3, 32'h0, 1'b1, 16 + 2);
    set_req(3, TAB_A[3], TAB_B[3]);
    wait_accepts(1, 0);
    wait_drain();
    stub_dead = 0;

    // After the timeout the pointer moves past requester 3 to requester 0.
    push_exp(2'd0, TAB_P[0], 1'b0, LAT + 3);
    push_exp(2'd3, TAB_P[3], 1'b0, LAT + 3);
    set_req(0, TAB_A[0], TAB_B[0]);
    set_req(3, TAB_A[3], TAB_B[3]);
    wait_accepts(2, 0);
    wait_drain();

    // Reset while waiting on the unit: response discarded, outputs cleared.
    push_exp(2'd1, TAB_P[1], 1'b0, LAT + 3);
    set_req(1, TAB_A[1], TAB_B[1]);
    wait_accepts(1, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    acc_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    push_exp(2'd2, TAB_P[2], 1'b0, LAT + 3);
    set_req(2, TAB_A[2], TAB_B[2]);
    wait_accepts(1, 0);
    wait_drain();

    repeat (3) @(posedge clk);
    #1;
    check_eq("sb_empty", 64'(exp_q.size()), 64'd0);
    check_eq("idle_end", {63'd0, busy}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lmul_scheduler.md
# lmul_scheduler

Shares one `LMUL_unit` BF16 multiplier among `N_REQ` requesters, e.g. the four LSTM gate datapaths (i, f, g, o).
- Arbitrates round-robin and captures the winner's operands.
- Sequences the unit's `start`/`ready` protocol.
- Returns the 32-bit result, tagged with the requester id, over a valid/ready response channel.
- Has a watchdog that converts a missing `ready` into an error response.

## Interface
- `N_REQ`, 4, number of requesters.
- `ID_W`, 2, requester id width; must satisfy 2^`ID_W` ≥ `N_REQ`.
- `TIMEOUT`, 16, maximum counted WAIT cycles before an error response; must be ≥ `LATENCY`+2 of the unit.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  `N_REQ`  per-requester request valid.
- `req_a`  in  `N_REQ`*16  flattened BF16 operand A; requester i at bits [16i+15:16i].
- `req_b`  in  `N_REQ`*16  flattened BF16 operand B, same layout.
- `req_ready`  out  `N_REQ`  one-hot accept strobe.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_id`  out  `ID_W`  requester id of the response.
- `rsp_data`  out  32  multiplier result; BF16 in the upper 16 bits.
- `rsp_err`  out  1  response produced by watchdog timeout.
- `mul_start`  out  1  start pulse to the `LMUL_unit`.
- `mul_a`, `mul_b`  out  16  operands to the unit.
- `mul_ready`  in  1  unit ready, level signal.
- `mul_out`  in  32  unit result.
- `busy`  out  1  high in any state other than IDLE.

## Operation
FSM states and transitions:
- **IDLE** → **ISSUE**:
  - The round-robin arbiter picks the first asserted `req_valid` starting from pointer `rr_ptr`.
  - `req_ready[g]` is driven combinationally for the granted index g only.
  - On `req_valid[g] && req_ready[g]`, operands are captured into `op_a`/`op_b` and g into `cur_id`.
- **ISSUE** (exactly one cycle):
  - `mul_start`=1.
  - `mul_a`/`mul_b` always equal `op_a`/`op_b`, in every state.
  - Goes to WAIT with `wait_cnt`=0.
- **WAIT**:
  - `wait_cnt` increments each cycle.
  - `mul_ready` is ignored in the first WAIT cycle (blanking).
  - On any later cycle, `mul_ready`=1: `rsp_data`←`mul_out`, `rsp_err`←0, go to RESP.
  - Else if `wait_cnt`==`TIMEOUT`-1: `rsp_data`←0, `rsp_err`←1, go to RESP.
- **RESP**:
  - `rsp_valid`=1; `rsp_id`=`cur_id`.
  - `rsp_data`, `rsp_err` and `rsp_id` are held stable until `rsp_valid && rsp_ready`.
  - On that handshake: `rr_ptr`←(`cur_id`+1) mod `N_REQ`, go to IDLE.

Rules and boundary behaviour:
- No request is accepted outside IDLE, so `req_ready`=0 in ISSUE, WAIT and RESP.
- Requesters must hold `req_valid` and their operands until accepted; a dropped request is simply not granted.
- The arbiter pointer wraps `N_REQ`-1 → 0.
- `rr_ptr` does not advance on a timeout until that response's handshake completes.
- `rsp_ready` already high when RESP is entered completes the handshake in that first RESP cycle.
- The earliest next accept is the following cycle; IDLE is never skipped.
- Reset mid-operation:
  - All state returns to IDLE, `rr_ptr`=0, and a pending response is discarded.
  - The unit itself is not reset; the next ISSUE restarts its counter.
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_err`=0, `mul_start`=0, `mul_a`=`mul_b`=0, `busy`=0.

## Timing
Latency, with the unit at `LATENCY`=5 and acceptance at edge A:
- ISSUE occupies cycle A→A+1; the unit samples `start` at A+1.
- The unit asserts `ready` after A+7.
- The controller samples it at A+8; `rsp_valid` is high from A+8.
- Total: `LATENCY`+3 cycles, acceptance to response.

Throughput:
- Minimum occupancy is `LATENCY`+5 cycles per operation with `rsp_ready` tied high.
- Timeout response: `rsp_valid` rises `TIMEOUT`+2 cycles after acceptance.
- All outputs are registered except `req_ready` and `busy`, which are decoded from state.

## Structure
- Shared package `lmul_pkg`:
  - BF16 width constant (16) and result width constant (32).
  - FSM state encoding: IDLE, ISSUE, WAIT, RESP.
  - Default `TIMEOUT`.
- Sub-module `rr_arbiter` (parameter `N`):
  - Inputs: `req`, `ptr`.
  - Outputs: one-hot `grant`, encoded `grant_id`, `any`.
  - Purely combinational; reused by later shared-resource schedulers.

## Test plan
- **Single request:** req 0, a=0x3F80, b=0x4000, real `LMUL_unit` → `rsp_valid` at A+8, `rsp_data`=0x4000_0000, `rsp_id`=0, `rsp_err`=0.
- **Sign:** a=0xBF80, b=0x4000 → `rsp_data`=0xC000_0000.
- **Round-robin:** all four `req_valid` held high, `rsp_ready`=1 → grant order 0,1,2,3,0; `rr_ptr` wraps correctly.
- **Backpressure:** `rsp_ready` held low for 5 cycles in RESP → `rsp_valid`, `rsp_data` and `rsp_id` stable; `req_ready` stays 0; accept resumes the cycle after the handshake.
- **Timeout:** stub holds `mul_ready`=0, `TIMEOUT`=16 → `rsp_err`=1 and `rsp_data`=0 at acceptance+18; next grant goes to the following requester.
- **Reset mid-WAIT:** `rst` pulsed during WAIT → all outputs at reset values immediately; a new request after reset completes with correct data.
